// File: rtl/dco_freq_cal.sv
// SAR frequency calibration for the accumulator DCO: binary-searches speed_var so the
// per-window toggle count does not exceed the target. Define DCO_CAL_TRACK_EN for post-lock tracking.
module dco_freq_cal #(
    parameter int BIT_COUNT  = 24,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     target_count,
    input  logic [CNT_W-1:0]     win_len,
    input  logic                 dco_sig,
    output logic [BIT_COUNT-1:0] speed_var,
    output logic [CNT_W-1:0]     meas_count,
    output logic                 busy,
    output logic                 done,
    output logic                 locked,
    output logic                 err
);

    localparam int IDX_W = $clog2(BIT_COUNT);
    localparam int SC_W  = $clog2(SETTLE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   EXT_ONE = (CNT_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, MEASURE, UPDATE, DONE, TRACK_SETTLE, TRACK_MEASURE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     tgt, win, wc, cnt, cnt_nxt;
    logic [SC_W-1:0]      sc;
    logic [IDX_W-1:0]     bit_idx;
    logic                 dco_q, done_r, tog, settle_end, win_end;

    assign tog        = dco_sig ^ dco_q;
    assign cnt_nxt    = (tog && cnt != '1) ? cnt + CNT_ONE : cnt;
    assign settle_end = (sc == SC_W'(SETTLE_CYC - 1));
    assign win_end    = (wc == win - CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:          if (start && win_len != '0) state_nxt = SETTLE;
                SETTLE:        if (settle_end) state_nxt = MEASURE;
                MEASURE:       if (win_end) state_nxt = UPDATE;
                UPDATE:        state_nxt = (bit_idx == '0) ? DONE : SETTLE;
`ifdef DCO_CAL_TRACK_EN
                DONE:          state_nxt = TRACK_SETTLE;
                TRACK_SETTLE:  if (settle_end) state_nxt = TRACK_MEASURE;
                TRACK_MEASURE: if (win_end) state_nxt = TRACK_SETTLE;
`else
                DONE:          state_nxt = IDLE;
`endif
                default:       state_nxt = IDLE;
            endcase
        end
    end

    // done is registered, so busy is held through the done cycle and drops one cycle later
    always_comb begin
        busy = (state != IDLE) || done_r;
        done = done_r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_var  <= '0;
            meas_count <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            done_r     <= 1'b0;
            tgt        <= '0;
            win        <= '0;
            wc         <= '0;
            cnt        <= '0;
            sc         <= '0;
            dco_q      <= 1'b0;
            bit_idx    <= IDX_W'(BIT_COUNT - 1);
        end else begin
            dco_q  <= dco_sig;
            done_r <= 1'b0;
            if (abort) begin
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (win_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            tgt       <= target_count;
                            win       <= win_len;
                            err       <= 1'b0;
                            locked    <= 1'b0;
                            speed_var <= {1'b1, {(BIT_COUNT-1){1'b0}}};
                            bit_idx   <= IDX_W'(BIT_COUNT - 1);
                            sc        <= '0;
                        end
                    end
                    SETTLE, TRACK_SETTLE: begin
                        if (settle_end) begin
                            cnt <= '0;
                            wc  <= '0;
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                    MEASURE: begin
                        cnt <= cnt_nxt;
                        wc  <= wc + CNT_ONE;
                    end
                    UPDATE: begin
                        meas_count <= cnt;
                        if (cnt > tgt) speed_var[bit_idx] <= 1'b0;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - IDX_W'(1);
                            speed_var[bit_idx - IDX_W'(1)] <= 1'b1;
                            sc <= '0;
                        end
                    end
                    DONE: begin
                        done_r <= 1'b1;
                        locked <= 1'b1;
                        sc     <= '0;
                    end
`ifdef DCO_CAL_TRACK_EN
                    // last window edge: decide on the count including this cycle's toggle
                    TRACK_MEASURE: begin
                        if (win_end) begin
                            meas_count <= cnt_nxt;
                            sc         <= '0;
                            if ({1'b0, cnt_nxt} > {1'b0, tgt} + EXT_ONE) begin
                                if (speed_var != '0) speed_var <= speed_var - BIT_COUNT'(1);
                            end else if ({1'b0, cnt_nxt} + EXT_ONE < {1'b0, tgt}) begin
                                if (speed_var != '1) speed_var <= speed_var + BIT_COUNT'(1);
                            end
                        end else begin
                            cnt <= cnt_nxt;
                            wc  <= wc + CNT_ONE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
